// File: rtl/keynsham_bus_initiator_if.sv
// Command, response and peripheral-bus signals of the keynsham bus initiator.
// master is the initiator's view; slave is the requester/bus-side view.
interface keynsham_bus_initiator_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [29:0] cmd_addr;
   logic        cmd_wr;
   logic [31:0] cmd_wr_val;
   logic [3:0]  cmd_bytesel;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_error;
   logic        bus_access;
   logic [29:0] bus_addr;
   logic [31:0] bus_wr_val;
   logic        bus_wr_en;
   logic [3:0]  bus_bytesel;
   logic [31:0] bus_data;
   logic        bus_ack;
   logic        bus_error;

   // Handshake: a transfer happens on a clk edge where valid and ready are both
   // high; valid and its payload stay stable until that edge.
   modport master (
      input  cmd_valid, cmd_addr, cmd_wr, cmd_wr_val, cmd_bytesel,
      output cmd_ready,
      output rsp_valid, rsp_data, rsp_error,
      input  rsp_ready,
      output bus_access, bus_addr, bus_wr_val, bus_wr_en, bus_bytesel,
      input  bus_data, bus_ack, bus_error
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_wr, cmd_wr_val, cmd_bytesel,
      input  cmd_ready,
      input  rsp_valid, rsp_data, rsp_error,
      output rsp_ready,
      input  bus_access, bus_addr, bus_wr_val, bus_wr_en, bus_bytesel,
      output bus_data, bus_ack, bus_error
   );
endinterface

// File: rtl/keynsham_bus_initiator.sv
// Single-outstanding peripheral bus initiator: one command in, one bus access,
// one response out, with a cycle timeout against absent slaves.
module keynsham_bus_initiator #(
   parameter int unsigned timeout_cycles = 255
) (
   input  logic                       clk,
   input  logic                       rst,
   keynsham_bus_initiator_if.master   bus,
   output logic [1:0]                 state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [15:0] last_cnt = 16'(timeout_cycles - 1);

   state_t      state;
   logic [15:0] cnt;
   logic        cmd_ready_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_data_q;
   logic        rsp_error_q;
   logic [29:0] addr_q;
   logic [31:0] wr_val_q;
   logic        wr_en_q;
   logic [3:0]  bytesel_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= 16'd0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 32'd0;
         rsp_error_q <= 1'b0;
         addr_q      <= 30'd0;
         wr_val_q    <= 32'd0;
         wr_en_q     <= 1'b0;
         bytesel_q   <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               cmd_ready_q <= 1'b1;
               if (bus.cmd_valid && cmd_ready_q) begin
                  state       <= BUS;
                  cmd_ready_q <= 1'b0;
                  cnt         <= 16'd0;
                  addr_q      <= bus.cmd_addr;
                  wr_val_q    <= bus.cmd_wr_val;
                  wr_en_q     <= bus.cmd_wr;
                  bytesel_q   <= bus.cmd_bytesel;
                  rsp_data_q  <= 32'd0;
                  rsp_error_q <= 1'b0;
               end
            end
            BUS: begin
               // Error outranks a same-cycle ack; the timeout only fires when
               // the slave stays silent through the last counted cycle.
               if (bus.bus_error) begin
                  state       <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_error_q <= 1'b1;
                  rsp_data_q  <= 32'd0;
                  wr_en_q     <= 1'b0;
               end else if (bus.bus_ack) begin
                  state       <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_error_q <= 1'b0;
                  rsp_data_q  <= wr_en_q ? 32'd0 : bus.bus_data;
                  wr_en_q     <= 1'b0;
               end else if (cnt == last_cnt) begin
                  state       <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_error_q <= 1'b1;
                  rsp_data_q  <= 32'd0;
                  wr_en_q     <= 1'b0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state       <= IDLE;
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               rsp_valid_q <= 1'b0;
               wr_en_q     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cmd_ready   = cmd_ready_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_data    = rsp_data_q;
   assign bus.rsp_error   = rsp_error_q;
   // Strobe drops in the completion cycle so a registered-ack slave sees it once.
   assign bus.bus_access  = (state == BUS) && !(bus.bus_ack || bus.bus_error);
   assign bus.bus_addr    = addr_q;
   assign bus.bus_wr_val  = wr_val_q;
   assign bus.bus_wr_en   = wr_en_q;
   assign bus.bus_bytesel = bytesel_q;
   assign state_dbg       = state;

endmodule

// File: doc/keynsham_bus_initiator.md
# keynsham_bus_initiator

Single-outstanding bus initiator for the keynsham SoC. It takes one read or write command at a time over a valid/ready command port, drives the shared peripheral bus, and waits for the addressed slave's `bus_ack`/`bus_error`. It returns the result over a valid/ready response port and enforces a timeout so a missing slave cannot hang the requester. It sits between debug/bridge logic and the bus address decoder; the decoder derives the per-slave `bus_cs` from `bus_addr`.

## Interface
- `timeout_cycles`, default 255: number of cycles in BUS without ack/error before forced error completion; legal range 1..65535.
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid` at a `clk` edge.
- `cmd_addr`  in  30  word address.
- `cmd_wr`  in  1  1 = write, 0 = read.
- `cmd_wr_val`  in  32  write data.
- `cmd_bytesel`  in  4  byte lane enables.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when high together with `rsp_valid`.
- `rsp_data`  out  32  read data; 0 for writes and errors.
- `rsp_error`  out  1  slave error or timeout.
- `bus_access`  out  1  transaction strobe.
- `bus_addr`  out  30  word address.
- `bus_wr_val`  out  32  write data.
- `bus_wr_en`  out  1  write enable.
- `bus_bytesel`  out  4  byte lane enables.
- `bus_data`  in  32  slave read data, the OR of all slaves; valid only with `bus_ack`.
- `bus_ack`  in  1  slave completion.
- `bus_error`  in  1  slave error completion.

## Operation
- FSM with three states:
  - IDLE: `cmd_ready`=1.
  - BUS: transaction on the bus.
  - RESP: `rsp_valid`=1.
- IDLE -> BUS on `cmd_valid & cmd_ready`. On that edge, `cmd_addr/cmd_wr/cmd_wr_val/cmd_bytesel` are registered into `bus_addr/bus_wr_en/bus_wr_val/bus_bytesel`, and the timeout counter (16 bit) is cleared.
- In BUS:
  - `bus_access = ~(bus_ack | bus_error)`, combinational, so the strobe drops in the completion cycle and a registered-ack slave acks exactly once.
  - `bus_addr/bus_wr_val/bus_wr_en/bus_bytesel` stay stable for the whole BUS state.
- BUS -> RESP cases:
  - `bus_error`=1: `rsp_error`=1, `rsp_data`=0. Error has priority over a simultaneous ack.
  - `bus_ack`=1 and no error: `rsp_error`=0. For a read, `rsp_data`=`bus_data` captured that cycle; for a write, `rsp_data`=0.
  - Counter == `timeout_cycles`-1 with no ack/error: `rsp_error`=1, `rsp_data`=0.
  - Otherwise the counter increments.
- RESP -> IDLE on `rsp_valid & rsp_ready`. `rsp_data/rsp_error` are held stable while `rsp_valid` is high and not yet accepted.
- Outside BUS:
  - `bus_ack`/`bus_error` are ignored, including a late ack arriving after a timeout.
  - `bus_access`=0 and `bus_wr_en`=0; `bus_addr/bus_wr_val/bus_bytesel` keep their last values.
- Only one transaction is ever outstanding; new commands are stalled (`cmd_ready`=0) in BUS and RESP.

## Timing
- Reset (async, mid-transaction included):
  - State forced to IDLE immediately.
  - All outputs are 0 while `rst` is high: `cmd_ready`, `rsp_valid`, `rsp_data`, `rsp_error`, `bus_access`, `bus_addr`, `bus_wr_val`, `bus_wr_en`, `bus_bytesel`.
  - `cmd_ready`=1 from the first cycle after `rst` deasserts.
  - An aborted bus transaction produces no response.
- Latency, counting the command accept edge as cycle 0:
  - `bus_access`=1 in cycle 1.
  - A 1-cycle registered-ack slave acks in cycle 2.
  - `rsp_valid`=1 in cycle 3.
  - With `rsp_ready`=1, `cmd_ready`=1 in cycle 4.
  - Maximum throughput is therefore one transaction per 4 cycles.
- Slave ack in cycle k after entry into BUS: `rsp_valid` in cycle k+1.
- Timeout: `bus_access` is high for exactly `timeout_cycles` cycles; `rsp_valid` rises in the following cycle.
- `cmd_ready` depends only on state (not on `cmd_valid`). `bus_access` is combinational only from state, `bus_ack` and `bus_error`.

## Test plan
- **Read:** cmd read at addr 0x0000_0001; slave acks in the next cycle with `bus_data`=0x0000_000F. Expect `bus_access` high for exactly 1 cycle with `bus_wr_en`=0, then `rsp_valid`=1 with `rsp_data`=0x0000_000F and `rsp_error`=0, 3 cycles after accept.
- **Write:** cmd write addr 0x0000_0002, `cmd_wr_val`=0x0000_0005, `cmd_bytesel`=4'hF. Expect the bus outputs to carry exactly those values with `bus_wr_en`=1 for one cycle; response `rsp_data`=0, `rsp_error`=0.
- **Slow slave and backpressure:** slave acks after 5 cycles, `rsp_ready` held low for 3 cycles. Expect `bus_access` high for 5 cycles with stable address. `rsp_valid`/`rsp_data` are held stable until accepted, and `cmd_ready` stays 0 throughout.
- **Error priority:** `bus_ack`=1 and `bus_error`=1 in the same cycle on a read returning 0xDEAD_BEEF. Expect `rsp_error`=1 and `rsp_data`=0.
- **Timeout:** `timeout_cycles`=4, no slave responds. Expect `bus_access` high for exactly 4 cycles, then `rsp_error`=1. A stray `bus_ack` injected 2 cycles later is ignored, and the next command completes normally.
- **Reset mid-BUS:** assert `rst` asynchronously (between edges) while `bus_access`=1. Expect all outputs 0 immediately and no `rsp_valid`. After release, `cmd_ready`=1 and a read completes correctly.
